brs_uart_rx_fifo: RTL and testbench

Serial front-end that feeds the BRS user core. It receives 8N1 UART frames on a single pin, buffers the decoded bytes in a small FIFO, and presents them as an 8-bit word stream with a valid/ready handshake. The core's dedicated-input port consumes that stream. It lets the core be driven from a host UART without a parallel bus.

---
 rtl/brs_pkg.sv | 20 ++
 rtl/brs_sync_fifo.sv | 58 +++++
 rtl/brs_uart_rx_fifo.sv | 196 +++++++++++++++++++
 tb/tb_brs_uart_rx_fifo.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brs_pkg.sv
// brs_pkg: shared types and constants for the BRS UART receive front-end.
//   rx_state_t     - receiver FSM state encoding
//   BYTE_W         - width of a received data word
//   CLK_DIV_DEF    - default clock cycles per UART bit
//   FIFO_DEPTH_DEF - default receive FIFO depth in bytes
package brs_pkg;

  localparam int BYTE_W         = 8;
  localparam int CLK_DIV_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/brs_sync_fifo.sv
// brs_sync_fifo: generic first-word fall-through FIFO.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push, din  - write request and data; a push while full is accepted only
//                when a pop happens in the same cycle
//   pop        - read request; ignored while empty
//   dout       - head entry, forced to zero while empty
//   full/empty - occupancy flags
//   level      - occupancy, one bit wider than the pointers
module brs_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset; dout is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/brs_uart_rx_fifo.sv
// brs_uart_rx_fifo: UART receiver (8N1, or 8E1 with BRS_PARITY_EN defined)
// feeding a FWFT byte FIFO with a valid/ready output stream.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   rx_i          - serial input, idle high, asynchronous to clk
//   clr_i         - synchronous clear of the sticky error flags
//   byte_o        - head-of-FIFO byte (zero while empty)
//   valid_o       - FIFO not empty
//   ready_i       - consumer accepts byte_o; pop on valid_o & ready_i
//   overrun_o     - sticky: a byte was dropped on a full FIFO
//   frame_err_o   - sticky: a frame ended with a low stop bit
//   parity_err_o  - sticky, BRS_PARITY_EN only: even-parity mismatch
//   level_o       - FIFO occupancy
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | line idle, waiting for rxs low
// START   | timing to mid start bit to confirm it is not a glitch
// DATA    | sampling 8 data bits LSB-first, one per CLK_DIV cycles
// PAR     | sampling the even-parity bit (BRS_PARITY_EN only)
// STOP    | sampling the stop bit, then push or flag the frame
module brs_uart_rx_fifo
  import brs_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          clr_i,
  output logic [BYTE_W-1:0]             byte_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o,
  output logic                          frame_err_o,
`ifdef BRS_PARITY_EN
  output logic                          parity_err_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LOAD_HALF = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] LOAD_FULL = CW'(CLK_DIV - 1);

  logic              rx_meta, rxs;
  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic              tc;
  logic              stop_ok, stop_bad;
  logic              push_d, push_q;
  logic [BYTE_W-1:0] data_q;
  logic              fifo_full, fifo_empty, pop;
`ifdef BRS_PARITY_EN
  logic              par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  assign tc = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tc ? cnt_q : cnt_q - 1'b1;
    shift_d  = shift_q;
    bit_d    = bit_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef BRS_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = LOAD_HALF;
        end
      end
      ST_START: begin
        if (tc) begin
          if (!rxs) begin
            state_d = ST_DATA;
            cnt_d   = LOAD_FULL;
            bit_d   = 3'd0;
`ifdef BRS_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_d = {rxs, shift_q[BYTE_W-1:1]};
          cnt_d   = LOAD_FULL;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef BRS_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef BRS_PARITY_EN
      ST_PAR: begin
        if (tc) begin
          par_bad_d = rxs ^ (^shift_q);
          cnt_d     = LOAD_FULL;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tc) begin
          state_d  = ST_IDLE;
          stop_ok  = rxs;
          stop_bad = ~rxs;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BRS_PARITY_EN
  assign push_d = stop_ok & ~par_bad_q;
`else
  assign push_d = stop_ok;
`endif

  assign pop = valid_o & ready_i;

  // The accepted byte is staged one cycle before entering the FIFO, so the
  // FSM is already back in IDLE when the FIFO sees the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      push_q      <= 1'b0;
      data_q      <= '0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef BRS_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      push_q      <= push_d;
      data_q      <= shift_q;
      overrun_o   <= (overrun_o & ~clr_i) | (push_q & fifo_full & ~pop);
      frame_err_o <= (frame_err_o & ~clr_i) | stop_bad;
`ifdef BRS_PARITY_EN
      par_bad_q    <= par_bad_d;
      // A bad stop bit takes priority: only frame_err_o is raised then.
      parity_err_o <= (parity_err_o & ~clr_i) | (stop_ok & par_bad_q);
`endif
    end
  end

  brs_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (data_q),
    .pop   (pop),
    .dout  (byte_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign valid_o = ~fifo_empty;

endmodule

// File: tb/tb_brs_uart_rx_fifo.sv
module tb_brs_uart_rx_fifo;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
`ifdef BRS_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LATENCY = 2 + (CLK_DIV * 19) / 2 + 1 + CLK_DIV;
`else
  localparam int NBITS   = 10;
  localparam int LATENCY = 2 + (CLK_DIV * 19) / 2 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       clr = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] byte_o;
  logic       valid_o;
  logic       overrun_o;
  logic       frame_err_o;
  logic [2:0] level_o;
`ifdef BRS_PARITY_EN
  logic       parity_err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  bit         m_ovr, m_ferr, m_perr;

  always #5 clk = ~clk;

  brs_uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .clr_i        (clr),
    .byte_o       (byte_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .overrun_o    (overrun_o),
    .frame_err_o  (frame_err_o),
`ifdef BRS_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .level_o      (level_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one frame, one bit per CLK_DIV cycles, changing on negedges. Loop
  // index c is the posedge number counted from the falling start edge.
  // pop_at forces ready high for posedge c==pop_at; abort_at stops early.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip,
                            input bit base_ready, input int pop_at, input int abort_at,
                            output int first_valid, output int valid_cycles,
                            output logic [7:0] first_byte);
    logic [11:0] bits;
    bits       = '1;
    bits[0]    = 1'b0;
    bits[8:1]  = d;
`ifdef BRS_PARITY_EN
    bits[9]    = (^d) ^ par_flip;
    bits[10]   = stop_bit;
`else
    bits[9]    = stop_bit;
`endif
    first_valid  = -1;
    valid_cycles = 0;
    first_byte   = 8'h00;
    for (int c = 0; c < NBITS * CLK_DIV; c++) begin
      if (c == abort_at) return;
      rx    = bits[c / CLK_DIV];
      ready = (c == pop_at) ? 1'b1 : base_ready;
      @(negedge clk);
      if (valid_o) begin
        valid_cycles++;
        if (first_valid < 0) begin
          first_valid = c;
          first_byte  = byte_o;
        end
      end
    end
    rx    = 1'b1;
    ready = base_ready;
    // A low stop bit looks like a new start edge; let it die out as a glitch.
    if (!stop_bit) repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  // Reference model of the receiver: a frame is either flagged, dropped on a
  // full queue, or appended.
  task automatic model_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    if (!stop_bit) m_ferr = 1'b1;
`ifdef BRS_PARITY_EN
    else if (par_flip) m_perr = 1'b1;
`endif
    else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(d);
  endtask

  task automatic send(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    int fv, vc;
    logic [7:0] fb;
    send_frame(d, stop_bit, par_flip, 1'b0, -1, -1, fv, vc, fb);
    model_frame(d, stop_bit, par_flip);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_overrun"}, overrun_o, m_ovr);
    check({tag, "_frame_err"}, frame_err_o, m_ferr);
`ifdef BRS_PARITY_EN
    check({tag, "_parity_err"}, parity_err_o, m_perr);
`endif
    check({tag, "_level"}, level_o, exp_q.size());
  endtask

  task automatic drain_all(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 2 * DEPTH) begin
      check({tag, "_valid"}, valid_o, 1);
      check({tag, "_byte"}, byte_o, exp_q[0]);
      ready = 1'b1;
      @(negedge clk);
      void'(exp_q.pop_front());
      guard++;
    end
    ready = 1'b0;
    check({tag, "_valid_after"}, valid_o, 0);
    check({tag, "_level_after"}, level_o, 0);
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_level;
    bit         exp_ovr;
    bit         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int fv, vc;
    logic [7:0] fb;

    tbl[0] = '{8'h01, 1'b1, 1, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 2, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b1, 3, 1'b0, 1'b0};
    tbl[3] = '{8'h04, 1'b1, 4, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 4, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 4, 1'b1, 1'b1};

    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_byte", byte_o, 0);
    check_flags("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency with ready held high: one cycle of valid, then popped
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, -1, fv, vc, fb);
    ready = 1'b0;
    check("lat_first_valid", fv, LATENCY);
    check("lat_byte", fb, 8'hA5);
    check("lat_valid_cycles", vc, 1);
    check("lat_level", level_o, 0);

    // Short low glitch: ignored, and the next frame is received
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check("glitch_valid", valid_o, 0);
    check_flags("glitch");
    send(8'h96, 1'b1, 1'b0);
    check_flags("post_glitch");
    drain_all("post_glitch");

    // Frame error: sticky until clr
    send(8'h3C, 1'b0, 1'b0);
    check("ferr_valid", valid_o, 0);
    check_flags("ferr");
    repeat (40) @(negedge clk);
    check("ferr_sticky", frame_err_o, 1);
    clear_flags();
    check_flags("ferr_clr");

    // Table: fill past full with ready low, then a bad frame on a full FIFO
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].data, tbl[i].stop, 1'b0);
      check($sformatf("tbl%0d_level", i), level_o, tbl[i].exp_level);
      check($sformatf("tbl%0d_ovr", i), overrun_o, tbl[i].exp_ovr);
      check($sformatf("tbl%0d_ferr", i), frame_err_o, tbl[i].exp_ferr);
      check($sformatf("tbl%0d_valid", i), valid_o, 1);
    end
    repeat (5) @(negedge clk);
    check("hold_byte", byte_o, 8'h01);
    drain_all("tbl_drain");
    clear_flags();
    check_flags("tbl_clr");

    // Full FIFO with a pop landing on the same edge as the 5th push. The push
    // reaches the FIFO at posedge LATENCY of the frame.
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b0, LATENCY, -1, fv, vc, fb);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h05);
    check_flags("popfull");
    check("popfull_level4", level_o, 4);
    drain_all("popfull_drain");

`ifdef BRS_PARITY_EN
    send(8'h07, 1'b1, 1'b1);
    check("par_bad_valid", valid_o, 0);
    check_flags("par_bad");
    send(8'h07, 1'b1, 1'b0);
    check("par_good_byte", byte_o, 8'h07);
    check_flags("par_good");
    drain_all("par_drain");
    clear_flags();
    check_flags("par_clr");
`endif

    // Reset during data bit 4 with content and a flag present
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    check_flags("pre_rst");
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, 5 * CLK_DIV + CLK_DIV / 2, fv, vc, fb);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    exp_q.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    check("midrst_valid", valid_o, 0);
    check("midrst_byte", byte_o, 0);
    check_flags("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send(8'h5A, 1'b1, 1'b0);
    check("after_rst_byte", byte_o, 8'h5A);
    check_flags("after_rst");
    drain_all("after_rst_drain");

    // Randomized rounds against the queue model, with random-ready draining
    for (int r = 0; r < 5; r++) begin
      int n;
      int guard;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        logic [7:0] d;
        bit sb, pf;
        d  = 8'($urandom);
        sb = ($urandom_range(0, 4) != 0);
`ifdef BRS_PARITY_EN
        pf = ($urandom_range(0, 4) == 0);
`else
        pf = 1'b0;
`endif
        send(d, sb, pf);
      end
      check_flags($sformatf("rnd%0d", r));
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
        check("rnd_valid", valid_o, 1);
        check("rnd_byte", byte_o, exp_q[0]);
        ready = 1'($urandom);
        @(negedge clk);
        if (ready) void'(exp_q.pop_front());
        guard++;
      end
      ready = 1'b0;
      check("rnd_drain_done", exp_q.size(), 0);
      check("rnd_valid_end", valid_o, 0);
      clear_flags();
      check_flags($sformatf("rnd%0d_clr", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
